// File: rtl/dct_mac_unit.sv
// dct_mac_unit: three-stage pipelined MAC that accumulates 64 pixel*cosine terms into one
// 2D-DCT coefficient F(u,v) and emits it rounded and saturated with a one-cycle valid pulse.
module dct_mac_unit #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 12,
    parameter int SHIFT = 16
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    clr_acc,
    input  logic                    act_mac,
    input  logic [2:0]              u,
    input  logic [2:0]              v,
    input  logic [2:0]              x,
    input  logic [2:0]              y,
    input  logic [7:0]              pixel,
    output logic signed [OUT_W-1:0] coef_out,
    output logic                    coef_valid,
    output logic [2:0]              coef_u,
    output logic [2:0]              coef_v,
    output logic                    sat,
    output logic                    busy
);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] MINV = -MAXV - 1;
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1 << (SHIFT-1));

    function automatic logic [7:0] cos_tab(input logic [2:0] i);
        logic [7:0] t;
        case (i)
            3'd0: t = 8'd128;
            3'd1: t = 8'd126;
            3'd2: t = 8'd118;
            3'd3: t = 8'd106;
            3'd4: t = 8'd91;
            3'd5: t = 8'd71;
            3'd6: t = 8'd49;
            default: t = 8'd25;
        endcase
        return t;
    endfunction

    // m folds (2n+1)k into one period of 32; quadrant picks table index and sign
    function automatic logic signed [15:0] cos_q7(input logic [2:0] k, input logic [2:0] n);
        logic [4:0] m;
        logic [2:0] i;
        logic signed [15:0] mag;
        m = {1'b0, n, 1'b1} * {2'b00, k};
        i = (m < 5'd8 || (m > 5'd16 && m < 5'd24)) ? m[2:0] :
            (m <= 5'd16) ? 3'(5'd16 - m) : 3'(5'd0 - m);
        mag = (k == 3'd0) ? 16'sd91 : (m == 5'd8 || m == 5'd24) ? 16'sd0 : $signed({8'd0, cos_tab(i)});
        return (m > 5'd8 && m < 5'd24) ? -mag : mag;
    endfunction

    logic signed [8:0]       r_d;
    logic signed [15:0]      r_cc;
    logic signed [ACC_W-1:0] r_p;
    logic signed [ACC_W-1:0] r_acc;
    logic [5:0]              r_cnt;
    logic                    r_vld0, r_vld1, r_fin;
    logic [2:0]              r_iu0, r_iv0, r_iu1, r_iv1, r_bu, r_bv;
    logic signed [15:0]      w_cc;
    logic signed [ACC_W-1:0] w_p;
    logic signed [ACC_W:0]   w_sh;
    logic                    w_hi, w_lo, w_emit;
    logic [OUT_W-1:0]        w_out;

    assign w_cc   = cos_q7(u, x) * cos_q7(v, y);
    assign w_p    = ACC_W'(r_d) * ACC_W'(r_cc);
    assign w_sh   = ($signed({r_acc[ACC_W-1], r_acc}) + HALF) >>> SHIFT;
    assign w_hi   = w_sh > MAXV;
    assign w_lo   = w_sh < MINV;
    assign w_out  = w_hi ? MAXV[OUT_W-1:0] : w_lo ? MINV[OUT_W-1:0] : w_sh[OUT_W-1:0];
    assign w_emit = r_fin & ~clr_acc;
    assign busy   = (r_cnt != 6'd0) | r_vld0 | r_vld1;

    // u/v ride along the pipeline so back-to-back blocks latch the indices of their own term 0
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_d        <= '0;
            r_cc       <= '0;
            r_p        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_vld0     <= 1'b0;
            r_vld1     <= 1'b0;
            r_fin      <= 1'b0;
            r_iu0      <= '0;
            r_iv0      <= '0;
            r_iu1      <= '0;
            r_iv1      <= '0;
            r_bu       <= '0;
            r_bv       <= '0;
            coef_out   <= '0;
            coef_valid <= 1'b0;
            coef_u     <= '0;
            coef_v     <= '0;
            sat        <= 1'b0;
        end else begin
            r_vld0 <= act_mac;
            r_vld1 <= r_vld0 & ~clr_acc;
            if (act_mac) begin
                r_d   <= $signed({1'b0, pixel}) - 9'sd128;
                r_cc  <= w_cc;
                r_iu0 <= u;
                r_iv0 <= v;
            end
            r_p   <= w_p;
            r_iu1 <= r_iu0;
            r_iv1 <= r_iv0;
            if (clr_acc) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_fin <= 1'b0;
            end else begin
                r_fin <= r_vld1 && r_cnt == 6'd63;
                if (r_vld1) begin
                    r_acc <= (r_cnt == 6'd0) ? r_p : r_acc + r_p;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd0) begin
                        r_bu <= r_iu1;
                        r_bv <= r_iv1;
                    end
                end
            end
            coef_valid <= w_emit;
            sat        <= w_emit & (w_hi | w_lo);
            if (w_emit) begin
                coef_out <= w_out;
                coef_u   <= r_bu;
                coef_v   <= r_bv;
            end
        end
    end
endmodule
